// File: rtl/tx_word_framer_pkg.sv
// tx_word_framer_pkg: shared FSM states, default words and the slip-width helper.
package tx_word_framer_pkg;
  typedef enum logic {TRAIN, DATA} state_e;
  localparam logic [7:0] TRAIN_PATTERN_DEF = 8'h0F;
  localparam logic [7:0] IDLE_WORD_DEF = 8'h00;
  function automatic int slip_w(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction
endpackage

// File: rtl/tx_word_framer_if.sv
// tx_word_framer_if: user word stream into the framer.
interface tx_word_framer_if #(parameter int DIN_WIDTH = 8);
  logic [DIN_WIDTH-1:0] s_data;
  logic s_valid;
  logic s_ready;
  modport master (output s_data, output s_valid, input s_ready);
  modport slave (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/tx_word_framer_slip_inject.sv
// tx_slip_inject: two-word history and bit-offset mux producing the registered output word.
module tx_slip_inject
  import tx_word_framer_pkg::*;
#(
  parameter int DIN_WIDTH = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [DIN_WIDTH-1:0]           word,
  input  logic [slip_w(DIN_WIDTH)-1:0]   slip_count,
  input  logic                           slip_load,
  output logic [DIN_WIDTH-1:0]           dout,
  output logic                           dout_valid
);
  localparam int SW = slip_w(DIN_WIDTH);
  logic [DIN_WIDTH-1:0] cur, prev;
  logic [SW-1:0] slip_r;
  logic fill;
  logic [2*DIN_WIDTH-1:0] pair;
  logic [SW:0] sh;
  assign pair = {cur, prev};
  // slip k pushes the newest word up by k bits; its top k bits spill into the next word
  assign sh = (SW+1)'(DIN_WIDTH) - {1'b0, slip_r};
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur <= '0;
      prev <= '0;
      slip_r <= '0;
      fill <= 1'b0;
      dout <= '0;
      dout_valid <= 1'b0;
    end else begin
      cur <= word;
      prev <= cur;
      fill <= 1'b1;
      dout_valid <= fill;
      dout <= pair[sh +: DIN_WIDTH];
      if (slip_load) slip_r <= slip_count;
    end
  end
endmodule

// File: rtl/tx_word_framer.sv
// tx_word_framer: training/data word source with idle fill and bit-offset injection.
module tx_word_framer
  import tx_word_framer_pkg::*;
#(
  parameter int                   DIN_WIDTH      = 8,
  parameter logic [DIN_WIDTH-1:0] TRAIN_PATTERN  = DIN_WIDTH'(TRAIN_PATTERN_DEF),
  parameter int                   TRAIN_WORDS    = 64,
  parameter logic [DIN_WIDTH-1:0] IDLE_WORD      = DIN_WIDTH'(IDLE_WORD_DEF),
  parameter int                   UNDERRUN_WIDTH = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  tx_word_framer_if.slave               src,
  input  logic                          train_req,
  input  logic [slip_w(DIN_WIDTH)-1:0]  slip_count,
  input  logic                          slip_load,
  output logic [DIN_WIDTH-1:0]          dout,
  output logic                          dout_valid,
  output logic                          training,
  output logic [UNDERRUN_WIDTH-1:0]     underrun_cnt
);
  localparam int CW = slip_w(TRAIN_WORDS);
  localparam logic [CW-1:0] LAST = CW'(TRAIN_WORDS - 1);
  state_e state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [UNDERRUN_WIDTH-1:0] under_nx;
  logic [DIN_WIDTH-1:0] word;
  assign src.s_ready = (state == DATA) && !train_req;
  assign training = (state == TRAIN);
  always_comb begin
    state_nx = state;
    cnt_nx = cnt;
    under_nx = underrun_cnt;
    word = TRAIN_PATTERN;
    if (state == TRAIN) begin
      cnt_nx = (cnt == LAST) ? cnt : cnt + 1'b1;
      state_nx = (cnt == LAST && !train_req) ? DATA : TRAIN;
    end else if (train_req) begin
      word = IDLE_WORD;
      state_nx = TRAIN;
      cnt_nx = '0;
    end else if (src.s_valid) begin
      word = src.s_data;
    end else begin
      word = IDLE_WORD;
      under_nx = (&underrun_cnt) ? underrun_cnt : underrun_cnt + 1'b1;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= TRAIN;
      cnt <= '0;
      underrun_cnt <= '0;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
      underrun_cnt <= under_nx;
    end
  end
  tx_slip_inject #(.DIN_WIDTH(DIN_WIDTH)) u_slip (
    .clk        (clk),
    .rst_n      (rst_n),
    .word       (word),
    .slip_count (slip_count),
    .slip_load  (slip_load),
    .dout       (dout),
    .dout_valid (dout_valid)
  );
endmodule

// File: tb/tb_tx_word_framer.sv
// tb_tx_word_framer: bit-stream reference model plus directed checks of the framer.
module tb_tx_word_framer;
  localparam int UW = 5;
  localparam int UMAX = (1 << UW) - 1;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic train_req = 1'b0;
  logic [2:0] slip_count = '0;
  logic slip_load = 1'b0;
  logic [7:0] dout;
  logic dout_valid, training;
  logic [UW-1:0] underrun_cnt;
  int checks = 0;
  int errors = 0;
  tx_word_framer_if #(.DIN_WIDTH(8)) intf ();
  tx_word_framer #(.UNDERRUN_WIDTH(UW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .src          (intf),
    .train_req    (train_req),
    .slip_count   (slip_count),
    .slip_load    (slip_load),
    .dout         (dout),
    .dout_valid   (dout_valid),
    .training     (training),
    .underrun_cnt (underrun_cnt)
  );
  always #5 clk = ~clk;
  task automatic cmp(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask
  // The model treats the output as the serial LSB-first stream of source words delayed by k bits.
  logic [7:0] hist[$];
  bit m_train = 1'b1;
  int m_cnt = 0, m_under = 0, m_k = 0, last_k = 0, adv = 0;
  logic [7:0] e_dout = '0;
  bit e_skip = 1'b0;
  function automatic logic [7:0] stream_word(input int n, input int k);
    logic [7:0] w = '0;
    logic [7:0] h;
    int p;
    for (int b = 0; b < 8; b++) begin
      p = 8 * n - k + b;
      if (p >= 0) begin
        h = hist[p / 8];
        w[b] = h[p % 8];
      end
    end
    return w;
  endfunction
  always @(negedge clk) begin
    logic [7:0] srcw;
    if (!rst_n) begin
      cmp("rst_dout", dout, 0);
      cmp("rst_valid", dout_valid, 0);
      cmp("rst_training", training, 1);
      cmp("rst_ready", intf.s_ready, 0);
      cmp("rst_underrun", underrun_cnt, 0);
      hist.delete();
      m_train = 1'b1; m_cnt = 0; m_under = 0; m_k = 0; last_k = 0; adv = 0;
      e_dout = '0; e_skip = 1'b0;
    end else begin
      cmp("m_valid", dout_valid, adv >= 2);
      if (!e_skip) cmp("m_dout", dout, e_dout);
      cmp("m_training", training, m_train);
      cmp("m_ready", intf.s_ready, !m_train && !train_req);
      cmp("m_underrun", underrun_cnt, m_under);
      e_skip = adv >= 1 && m_k != last_k;
      last_k = m_k;
      e_dout = stream_word(hist.size() - 1, m_k);
      if (m_train) begin
        srcw = 8'h0F;
        if (m_cnt == 63 && !train_req) m_train = 1'b0;
        if (m_cnt < 63) m_cnt++;
      end else if (train_req) begin
        srcw = 8'h00; m_train = 1'b1; m_cnt = 0;
      end else if (intf.s_valid) begin
        srcw = intf.s_data;
      end else begin
        srcw = 8'h00;
        if (m_under < UMAX) m_under++;
      end
      hist.push_back(srcw);
      if (slip_load) m_k = int'(slip_count);
      adv++;
    end
  end
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  initial begin
    int n0f, n55, u0;
    logic [7:0] d2, d3, d4;
    logic [15:0] pr;
    intf.s_valid = 1'b0;
    intf.s_data = '0;
    tick(2);
    cmp("init_dout", dout, 0);
    cmp("init_valid", dout_valid, 0);
    cmp("init_training", training, 1);
    rst_n = 1'b1;
    n0f = 0;
    for (int i = 1; i <= 66; i++) begin
      tick(1);
      if (dout_valid && dout == 8'h0F) n0f++;
      if (i == 1) cmp("first_valid", dout_valid, 0);
      if (i == 2) begin
        cmp("t1_dout", dout, 8'h0F);
        cmp("t1_valid", dout_valid, 1);
      end
      if (i == 63) cmp("train_hold", training, 1);
      if (i == 64) begin
        cmp("train_exit", training, 0);
        cmp("ready_up", intf.s_ready, 1);
      end
    end
    cmp("train_words", n0f, 64);
    intf.s_valid = 1'b1; intf.s_data = 8'h11;
    tick(1); intf.s_data = 8'h22;
    tick(1); cmp("d11", dout, 8'h11); intf.s_data = 8'h33;
    tick(1); cmp("d22", dout, 8'h22); intf.s_valid = 1'b0;
    tick(1); cmp("d33", dout, 8'h33);
    u0 = int'(underrun_cnt);
    tick(5);
    cmp("under_plus5", underrun_cnt, 16'(u0 + 5));
    cmp("idle_word", dout, 8'h00);
    tick(40);
    cmp("under_sat", underrun_cnt, 16'(UMAX));
    slip_count = 3'd4; slip_load = 1'b1;
    tick(1); slip_load = 1'b0;
    tick(2);
    intf.s_valid = 1'b1; intf.s_data = 8'hAB;
    tick(1); intf.s_data = 8'hCD;
    tick(1); intf.s_valid = 1'b0; d2 = dout; cmp("slip_b0", d2, 8'hB0);
    tick(1); d3 = dout; cmp("slip_da", d3, 8'hDA);
    tick(1); d4 = dout; cmp("slip_0c", d4, 8'h0C);
    pr = {d3, d2}; cmp("rx_ab", pr[11:4], 8'hAB);
    pr = {d4, d3}; cmp("rx_cd", pr[11:4], 8'hCD);
    slip_count = 3'd0; slip_load = 1'b1;
    tick(1); slip_load = 1'b0;
    tick(2);
    train_req = 1'b1; intf.s_valid = 1'b1; intf.s_data = 8'h55;
    #1 cmp("req_ready", intf.s_ready, 0);
    tick(1);
    cmp("req_training", training, 1);
    train_req = 1'b0; intf.s_valid = 1'b0;
    n55 = 0;
    for (int i = 0; i < 6; i++) begin
      tick(1);
      if (dout == 8'h55) n55++;
    end
    cmp("not_consumed", n55, 0);
    slip_count = 3'd3; slip_load = 1'b1;
    tick(1); slip_load = 1'b0;
    tick(3);
    cmp("train_slip3", dout, 8'h78);
    cmp("still_train", training, 1);
    rst_n = 1'b0;
    #1;
    cmp("mid_rst_dout", dout, 0);
    cmp("mid_rst_valid", dout_valid, 0);
    cmp("mid_rst_training", training, 1);
    cmp("mid_rst_ready", intf.s_ready, 0);
    tick(2);
    rst_n = 1'b1;
    tick(2);
    cmp("restart_dout", dout, 8'h0F);
    cmp("restart_valid", dout_valid, 1);
    tick(3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
